sr16_serializer: RTL

- Transmit end of the 1/2-bit-per-cycle serial link: accepts 16-bit words over a valid/ready handshake and shifts them out MSB-first on a 2-bit data bus with a ctrl qualifier.
- ctrl=01: one bit valid, on dataout[0]. ctrl=11: two bits valid, dataout[1] older, dataout[0] newer. ctrl=00: idle.
- One holding register plus the active shifter give back-to-back words with no gap; in 2-bit mode a word boundary may fall inside one beat.
- Feeds the 16-bit deserializer on the same link.

---
 rtl/sr16_serializer_pkg.sv | 16 +
 rtl/sr16_serializer_if.sv | 12 +
 rtl/sr16_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sr16_serializer_pkg.sv
// Shared definitions for the 16-bit serializer: word width, beat qualifiers
// and the LEAD/SHIFT state encoding.
package sr16_serializer_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_ONE  = 2'b01;
  localparam logic [1:0] CTRL_TWO  = 2'b11;

  typedef enum logic {
    ST_LEAD,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/sr16_serializer_if.sv
// Word-side valid/ready handshake into the serializer.
interface sr16_serializer_if;
  import sr16_serializer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/sr16_serializer.sv
// Transmit end of the 1/2-bit serial link: one holding register feeding a
// 16-bit shifter, emitted MSB-first with a ctrl qualifier per beat.
module sr16_serializer
  import sr16_serializer_pkg::*;
#(
  parameter int unsigned LEAD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  sr16_serializer_if.slave    src,
  input  logic                wide,
  input  logic                en,
  output logic [1:0]          dataout,
  output logic [1:0]          ctrl,
  output logic                busy,
  output logic                underrun
);

  localparam logic [3:0] PAD_LAST    = (LEAD > 0) ? 4'(LEAD - 1) : 4'd0;
  localparam state_t     RESET_STATE = (LEAD > 0) ? ST_LEAD : ST_SHIFT;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        pad_q, pad_d;
  logic [1:0]        ctrl_d, dataout_d;
  logic              underrun_d;
  logic              consume;
  logic              shifted;

  assign src.in_ready = ~hold_full_q;
  assign busy         = (state_q == ST_LEAD) || (cnt_q != 5'd0) || hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    pad_d       = pad_q;
    ctrl_d      = CTRL_IDLE;
    dataout_d   = 2'b00;
    consume     = 1'b0;
    shifted     = 1'b0;

    if (en) begin
      case (state_q)
        ST_LEAD: begin
          ctrl_d = CTRL_ONE;
          if (pad_q == PAD_LAST) begin
            state_d = ST_SHIFT;
          end else begin
            pad_d = pad_q + 4'd1;
          end
        end

        ST_SHIFT: begin
          if (wide && (cnt_q >= 5'd2)) begin
            ctrl_d    = CTRL_TWO;
            dataout_d = sh_q[15:14];
            sh_d      = {sh_q[13:0], 2'b00};
            cnt_d     = cnt_q - 5'd2;
            shifted   = 1'b1;
          end else if (!wide && (cnt_q != 5'd0)) begin
            ctrl_d    = CTRL_ONE;
            dataout_d = {1'b0, sh_q[15]};
            sh_d      = {sh_q[14:0], 1'b0};
            cnt_d     = cnt_q - 5'd1;
            shifted   = 1'b1;
          end else if ((cnt_q == 5'd1) && hold_full_q) begin
            // Word boundary inside one wide beat: last old bit plus first new bit.
            ctrl_d    = CTRL_TWO;
            dataout_d = {sh_q[15], hold_q[15]};
            sh_d      = {hold_q[14:0], 1'b0};
            cnt_d     = 5'd15;
            consume   = 1'b1;
          end else if (cnt_q == 5'd1) begin
            ctrl_d    = CTRL_ONE;
            dataout_d = {1'b0, sh_q[15]};
            sh_d      = {sh_q[14:0], 1'b0};
            cnt_d     = 5'd0;
          end else if (hold_full_q) begin
            sh_d    = hold_q;
            cnt_d   = 5'(WORD_W);
            consume = 1'b1;
          end

          // Reload on the same edge the shifter drains so words run back to back.
          if (shifted && (cnt_d == 5'd0) && hold_full_q) begin
            sh_d    = hold_q;
            cnt_d   = 5'(WORD_W);
            consume = 1'b1;
          end
        end

        default: begin
          state_d = ST_SHIFT;
        end
      endcase
    end

    if (consume) begin
      hold_full_d = 1'b0;
    end
    if (src.in_valid && !hold_full_q) begin
      hold_d      = src.in_data;
      hold_full_d = 1'b1;
    end

    underrun_d = en && (ctrl_d == CTRL_IDLE) && (ctrl != CTRL_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= 5'd0;
      pad_q       <= 4'd0;
      ctrl        <= CTRL_IDLE;
      dataout     <= 2'b00;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      pad_q       <= pad_d;
      ctrl        <= ctrl_d;
      dataout     <= dataout_d;
      underrun    <= underrun_d;
    end
  end

endmodule
